// File: rtl/fibre_a_arbiter.sv
// Round-robin sharing of one fibre_a read port across NUM_REQ tppe requesters.
// Returns arrive in issue order and are steered back by an in-order tag FIFO.

module fibre_a_arb_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic read_en,
  input  logic set,
  input  logic clr,
  input  logic vld,
  output logic pending,
  output logic elig
);
  // set and clr never coincide: a lane can only be granted while not pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pending <= 1'b0;
    else if (set) pending <= 1'b1;
    else if (clr) pending <= 1'b0;
  end

  assign elig = read_en & ~pending & ~vld;
endmodule

module fibre_a_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 8,
  parameter int TIMESTEPS       = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1,
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_read_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_valid,
  output logic [TIMESTEPS-1:0]          req_data,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_read_en,
  input  logic [TIMESTEPS-1:0]          mem_data,
  input  logic                          mem_valid,
  output logic [CW-1:0]                 outstanding,
  output logic                          orphan_err
);
  logic [NUM_REQ-1:0]    elig, pending, set_v, clr_v;
  logic [IW-1:0]         rr, win, head, rr_nxt;
  logic                  any_elig, full, empty, pop, issue;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [IW-1:0]         tag_mem [2**PW];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;

  assign full  = (cnt == CW'(MAX_OUTSTANDING));
  assign empty = (cnt == '0);
  assign head  = tag_mem[rd_ptr];
  assign pop   = mem_valid & ~empty;
  // a same-cycle pop frees the slot the new issue needs
  assign issue = any_elig & (~full | pop);
  assign set_v = issue ? (NUM_REQ'(1) << win) : '0;
  assign clr_v = pop   ? (NUM_REQ'(1) << head) : '0;
  assign rr_nxt = (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  assign outstanding = cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fibre_a_arb_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .read_en (req_read_en[g]),
      .set     (set_v[g]),
      .clr     (clr_v[g]),
      .vld     (req_valid[g]),
      .pending (pending[g]),
      .elig    (elig[g])
    );
  end

  // first eligible index at or above rr, wrapping
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr) + k) % NUM_REQ;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        win      = IW'(idx);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == IW'(i)) win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_gnt     <= '0;
      req_valid   <= '0;
      req_data    <= '0;
      mem_addr    <= '0;
      mem_read_en <= 1'b0;
      orphan_err  <= 1'b0;
      rr          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
    end else begin
      mem_read_en <= issue;
      req_gnt     <= set_v;
      req_valid   <= clr_v;
      // mem_addr holds between issues; only meaningful with mem_read_en
      if (issue) begin
        mem_addr <= win_addr;
        wr_ptr   <= wr_ptr + 1'b1;
        rr       <= rr_nxt;
      end
      if (pop) begin
        req_data <= mem_data;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (issue && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !issue) cnt <= cnt - 1'b1;
      if (mem_valid && empty) orphan_err <= 1'b1;
    end
  end
endmodule
